// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;

    localparam logic [1:0] LSU_BYTE = 2'b00;
    localparam logic [1:0] LSU_HALF = 2'b01;
    localparam logic [1:0] LSU_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_MERGE,
        S_RESP,
        S_ERR
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane logic for the load/store unit: load extract/extend, sub-word store merge
// and misalignment detect (active only when LSU_MISALIGN_TRAP_EN is defined).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [31:0] merge_word,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Little-endian lanes: byte k at [8k+7:8k], halfword picked by addr[1].
    always_comb begin
        byte_lane = rdata[{addr_lo, 3'b000} +: 8];
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            LSU_BYTE: load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            LSU_HALF: load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
            default:  load_data = rdata;
        endcase
    end

    always_comb begin
        store_word = merge_word;
        case (size)
            LSU_BYTE: store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            LSU_HALF: store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default:  store_word = wdata;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((size == LSU_HALF) && addr_lo[0]) ||
                        (size[1] && (addr_lo != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide data memory; sub-word stores use
// read-modify-write. Misaligned trapping is enabled by LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output lsu_state_e  dbg_state
);

    // Handshakes: a request transfers on a rising edge with req_valid && req_ready,
    // a response transfers on a rising edge with resp_valid && resp_ready; a
    // response, once valid, holds its payload until it transfers.

    lsu_state_e  state, next_state;
    logic        st_store, st_signed;
    logic [1:0]  st_size;
    logic [31:0] st_addr, st_wdata, merge_q, rdata_q;

    logic        in_idle;
    logic [1:0]  align_size;
    logic [1:0]  align_addr_lo;
    logic [31:0] load_data, store_word;
    logic        misaligned;

    assign in_idle       = (state == S_IDLE);
    assign align_size    = in_idle ? req_size : st_size;
    assign align_addr_lo = in_idle ? req_addr[1:0] : st_addr[1:0];

    lsu_align u_align (
        .size       (align_size),
        .sign_ext   (st_signed),
        .addr_lo    (align_addr_lo),
        .rdata      (mem_rdata),
        .wdata      (st_wdata),
        .merge_word (merge_q),
        .load_data  (load_data),
        .store_word (store_word),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_store  <= 1'b0;
            st_signed <= 1'b0;
            st_size   <= LSU_BYTE;
            st_addr   <= '0;
            st_wdata  <= '0;
            merge_q   <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        st_store  <= req_store;
                        st_signed <= req_signed;
                        st_size   <= req_size;
                        st_addr   <= req_addr;
                        st_wdata  <= req_wdata;
                        // Stores and errors report zero data.
                        rdata_q   <= '0;
                    end
                end
                S_ACCESS: begin
                    if (!st_store)       rdata_q <= load_data;
                    else if (!st_size[1]) merge_q <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = misaligned ? S_ERR : S_ACCESS;
            end
            S_ACCESS: begin
                mem_addr = {2'b00, st_addr[31:2]};
                if (st_store && st_size[1]) begin
                    mem_we    = 1'b1;
                    mem_wdata = st_wdata;
                end
                next_state = (st_store && !st_size[1]) ? S_MERGE : S_RESP;
            end
            S_MERGE: begin
                mem_addr   = {2'b00, st_addr[31:2]};
                mem_we     = 1'b1;
                mem_wdata  = store_word;
                next_state = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) next_state = S_IDLE;
            end
            S_ERR: begin
                resp_valid = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                resp_err   = 1'b1;
`endif
                if (resp_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign resp_rdata = rdata_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written
// stall/reset/misalign sequences, then random traffic against a word-array model.
module tb_load_store_unit;
    import lsu_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_store, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    lsu_state_e  dbg_state;

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset / memory fixture ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [16];
    logic        init_we;
    logic [3:0]  init_idx;
    logic [31:0] init_data;

    assign mem_rdata = mem[mem_addr[3:0]];
    always @(posedge clk) begin
        if (init_we)     mem[init_idx] <= init_data;
        else if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
    end

    // ---------------- scoreboard / model ----------------
    logic [31:0] ref_mem [16];
    logic [32:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(input string name, input int id,
                                  input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s txn=%0d got=%h want=%h", name, id, act, exp);
        end
    endfunction

    // Access model: words in an array, lanes by shift/mask arithmetic.
    function automatic void ref_txn(input logic st, input logic [1:0] sz, input logic sg,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    output logic [31:0] rd, output logic er);
        logic [31:0] old, mask, lane;
        int nbytes, sh;
        er = TRAP_EN && (((sz == 2'd1) && a[0]) || (sz[1] && (a[1:0] != 2'b00)));
        rd = '0;
        if (!er) begin
            old    = ref_mem[a[5:2]];
            nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            sh     = (nbytes == 1) ? 8 * int'(a[1:0]) : (nbytes == 2) ? 16 * int'(a[1]) : 0;
            mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1) << sh;
            if (st) begin
                ref_mem[a[5:2]] = (old & ~mask) | ((wd << sh) & mask);
            end else begin
                lane = (old & mask) >> sh;
                if (sg && nbytes < 4 && lane[8 * nbytes - 1]) lane = lane | ~(mask >> sh);
                rd = lane;
            end
        end
    endfunction

    // ---------------- driver ----------------
    task automatic run_txn(input int id, input logic st, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd, input int hold,
                           output logic [31:0] got_rd, output int got_lat);
        logic [31:0] exp_rd, acc_addr, we_addr, we_data;
        logic        exp_err, overlap;
        logic [32:0] exp;
        int          exp_lat, exp_we_k, we_cnt, we_k, lat;
        ref_txn(st, sz, sg, a, wd, exp_rd, exp_err);
        exp_q.push_back({exp_err, exp_rd});
        exp_lat  = exp_err ? 1 : (st && !sz[1]) ? 3 : 2;
        exp_we_k = (exp_err || !st) ? 0 : (!sz[1] ? 2 : 1);

        @(negedge clk);
        check("req_ready_idle", id, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        // Scramble request fields so later cycles prove the unit latched them.
        req_valid  = 1'b0;
        req_store  = ~st;
        req_size   = 2'($urandom_range(0, 3));
        req_signed = ~sg;
        req_addr   = $urandom;
        req_wdata  = $urandom;

        lat = 0; we_cnt = 0; we_k = 0; overlap = 1'b0;
        acc_addr = '0; we_addr = '0; we_data = '0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (req_ready) overlap = 1'b1;
            if (k == 1) acc_addr = mem_addr;
            if (mem_we) begin
                we_cnt++;
                we_k    = k;
                we_addr = mem_addr;
                we_data = mem_wdata;
            end
            if (resp_valid) lat = k;
        end
        exp     = exp_q.pop_front();
        got_rd  = resp_rdata;
        got_lat = lat;
        if (lat == 0) begin
            check("resp_timeout", id, 32'd0, 32'd1);
        end else begin
            check("resp_rdata", id, resp_rdata, exp[31:0]);
            check("resp_err", id, 32'(resp_err), 32'(exp[32]));
            check("latency", id, 32'(lat), 32'(exp_lat));
            check("we_count", id, 32'(we_cnt), (exp_we_k != 0) ? 32'd1 : 32'd0);
            check("we_cycle", id, 32'(we_k), 32'(exp_we_k));
            check("no_overlap", id, 32'(overlap), 32'd0);
            if (!exp_err) check("access_addr", id, acc_addr, {26'd0, a[7:2]} & 32'h0000_003F);
            if (exp_we_k != 0) begin
                check("we_addr", id, we_addr, 32'(a[31:2]));
                check("we_data", id, we_data, ref_mem[a[5:2]]);
            end
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("stall_valid", id, 32'(resp_valid), 32'd1);
                check("stall_rdata", id, resp_rdata, exp[31:0]);
                check("stall_err", id, 32'(resp_err), 32'(exp[32]));
                check("stall_ready", id, 32'(req_ready), 32'd0);
                check("stall_we", id, 32'(mem_we), 32'd0);
            end
            resp_ready = 1'b1;
            @(posedge clk);
            #1;
            resp_ready = 1'b0;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [31:0] rd;
        int          lat;

        vecs[0]  = '{1'b0, 2'b00, 1'b1, 32'h5, 32'h0,         32'hFFFF_FF86, 2};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h5, 32'h0,         32'h0000_0086, 2};
        vecs[2]  = '{1'b0, 2'b01, 1'b0, 32'h4, 32'h0,         32'h0000_8610, 2};
        vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h4, 32'h0,         32'h0000_8610, 2};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 32'h2, 32'h1234_56AB, 32'h0,         3};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h0, 32'h0,         32'h00AB_4430, 2};
        vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h4, 32'h0,         32'hFFFF_8610, 2};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h6, 32'h7777_BEEF, 32'h0,         3};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h4, 32'h0,         32'hBEEF_8610, 2};
        vecs[9]  = '{1'b0, 2'b00, 1'b1, 32'h7, 32'h0,         32'hFFFF_FFBE, 2};
        vecs[10] = '{1'b0, 2'b00, 1'b1, 32'h3, 32'h0,         32'h0000_0000, 2};
        vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h8, 32'h1234_5678, 32'h0,         2};
        vecs[12] = '{1'b0, 2'b01, 1'b1, 32'hA, 32'h0,         32'h0000_1234, 2};
        vecs[13] = '{1'b0, 2'b11, 1'b1, 32'h8, 32'h0,         32'h1234_5678, 2};
        vecs[14] = '{1'b0, 2'b00, 1'b0, 32'h9, 32'h0,         32'h0000_0056, 2};

        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        init_we = 1'b0; init_idx = '0; init_data = '0;

        // Preload memory and model while reset holds the unit idle.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            init_we   = 1'b1;
            init_idx  = 4'(i);
            init_data = (i == 0) ? 32'h0000_4430 : (i == 1) ? 32'h0000_8610 : $urandom;
            ref_mem[i] = init_data;
        end
        @(negedge clk);
        init_we = 1'b0;

        check("rst_req_ready", 0, 32'(req_ready), 32'd1);
        check("rst_resp_valid", 0, 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", 0, resp_rdata, 32'd0);
        check("rst_resp_err", 0, 32'(resp_err), 32'd0);
        check("rst_mem_we", 0, 32'(mem_we), 32'd0);
        check("rst_mem_addr", 0, mem_addr, 32'd0);
        check("rst_mem_wdata", 0, mem_wdata, 32'd0);
        check("rst_state", 0, 32'(dbg_state), 32'(S_IDLE));
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_txn(i, vecs[i].st, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, 0, rd, lat);
            check("vec_rdata", i, rd, vecs[i].exp_rd);
            check("vec_latency", i, 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Stalled response, then a back-to-back request.
        run_txn(100, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 3, rd, lat);
        run_txn(101, 1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 0, rd, lat);
        check("b2b_rdata", 101, rd, 32'h0000_0012);

        // Misaligned word store: trapped, or written to word index 1.
        run_txn(102, 1'b1, 2'b10, 1'b0, 32'h6, 32'hCAFE_F00D, 1, rd, lat);
        run_txn(103, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 0, rd, lat);
        check("misalign_after", 103, rd, TRAP_EN ? 32'hBEEF_8610 : 32'hCAFE_F00D);

        // Reset during MERGE of a halfword store: no write reaches memory.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b01; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0000_5555;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("merge_we", 200, 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_we", 200, 32'(mem_we), 32'd0);
        check("rst_mid_ready", 200, 32'(req_ready), 32'd1);
        check("rst_mid_valid", 200, 32'(resp_valid), 32'd0);
        check("rst_mid_rdata", 200, resp_rdata, 32'd0);
        check("rst_mid_err", 200, 32'(resp_err), 32'd0);
        check("rst_mid_addr", 200, mem_addr, 32'd0);
        check("rst_mid_wdata", 200, mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_mem0", 200, mem[0], 32'h00AB_4430);
        run_txn(201, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, rd, lat);

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            run_txn(300 + i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                    $urandom_range(0, 2), rd, lat);
        end

        @(negedge clk);
        for (int i = 0; i < 16; i++) check("final_mem", i, mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
